// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer.
// Entry layout: [22:21] duty, [20:17] volume, [16:6] period, [5:0] duration.
package note_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PLAY,
      HOST
   } seq_state_e;

   localparam int ENTRY_W  = 23;
   localparam int DUTY_LSB = 21;
   localparam int DUTY_W   = 2;
   localparam int VOL_LSB  = 17;
   localparam int VOL_W    = 4;
   localparam int PER_LSB  = 6;
   localparam int PER_W    = 11;
   localparam int DUR_LSB  = 0;
   localparam int DUR_W    = 6;

   typedef logic [ENTRY_W-1:0] entry_t;

   // Reset value of reg_4000: duty 0, halt+constant flags set, volume 0.
   localparam logic [7:0] MUTE_4000 = 8'h30;

   function automatic logic [DUTY_W-1:0] ent_duty(entry_t e);
      return e[DUTY_LSB +: DUTY_W];
   endfunction

   function automatic logic [VOL_W-1:0] ent_vol(entry_t e);
      return e[VOL_LSB +: VOL_W];
   endfunction

   function automatic logic [PER_W-1:0] ent_per(entry_t e);
      return e[PER_LSB +: PER_W];
   endfunction

   function automatic logic [DUR_W-1:0] ent_dur(entry_t e);
      return e[DUR_LSB +: DUR_W];
   endfunction

   // Silence the channel: clear volume, keep duty and flags.
   function automatic logic [7:0] mute_4000(logic [7:0] r);
      return {r[7:4], 4'h0};
   endfunction

endpackage

// File: rtl/note_sequencer_seq_table.sv
// Pattern table: synchronous write, registered read.
// A read and write of the same address in one cycle returns the old entry.
module seq_table
   import note_sequencer_pkg::*;
#(
   parameter int STEPS = 16,
   localparam int AW = $clog2(STEPS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [ENTRY_W-1:0] rdata
);

   entry_t mem [STEPS];

   // Storage write and registered read; no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/note_sequencer.sv
// Frame-ticked note sequencer driving the APU rectangle registers.
// Define NOTE_SEQUENCER_HOST_OVERRIDE_EN to let the UART host take over.
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int STEPS = 16,
   localparam int AW = $clog2(STEPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic          tbl_we,
   input  logic [AW-1:0] tbl_addr,
   input  logic [ENTRY_W-1:0] tbl_data,
   input  logic [31:0]   host_regs,
   input  logic          host_change,
   input  logic          host_release,
   output logic [7:0]    reg_4000,
   output logic [7:0]    reg_4001,
   output logic [7:0]    reg_4002,
   output logic [7:0]    reg_4003,
   output logic          reg_change,
   output logic          busy,
   output logic [AW-1:0] step
);

   seq_state_e state_q, state_d;
   logic [AW-1:0] step_q, step_d;
   logic [DUR_W-1:0] cnt_q, cnt_d;
   logic [7:0] r0_q, r0_d;
   logic [7:0] r1_q, r1_d;
   logic [7:0] r2_q, r2_d;
   logic [7:0] r3_q, r3_d;
   logic chg_q, chg_d;
   entry_t rd_data;
   logic [PER_W-1:0] per;

`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
   seq_state_e prev_q, prev_d;
`else
   logic unused_host;
   assign unused_host = ^{host_regs, host_change, host_release};
`endif

   // The read address follows the next step so the entry is ready in FETCH.
   seq_table #(.STEPS(STEPS)) u_table (
      .clk   (clk),
      .we    (tbl_we),
      .waddr (tbl_addr),
      .wdata (tbl_data),
      .raddr (step_d),
      .rdata (rd_data)
   );

   assign per = ent_per(rd_data);

   // Next-state, step/counter and register image.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      r3_d    = r3_q;
      chg_d   = 1'b0;
`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
      prev_d  = prev_q;
`endif
      if (stop) begin
         state_d = IDLE;
         r0_d    = mute_4000(r0_q);
         chg_d   = 1'b1;
      end
`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
      else if (host_change && state_q != HOST) begin
         prev_d  = state_q;
         state_d = HOST;
         {r3_d, r2_d, r1_d, r0_d} = host_regs;
         chg_d   = 1'b1;
      end
`endif
      else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = FETCH;
                  step_d  = '0;
               end
            end
            FETCH: begin
               if (ent_dur(rd_data) != '0) begin
                  state_d = PLAY;
                  cnt_d   = ent_dur(rd_data);
                  r0_d    = {ent_duty(rd_data), 2'b11,
                             ent_vol(rd_data)};
                  r1_d    = 8'h00;
                  r2_d    = per[7:0];
                  r3_d    = {5'b0, per[10:8]};
                  chg_d   = 1'b1;
               end else if (loop && step_q != '0) begin
                  step_d = '0;
               end else begin
                  state_d = IDLE;
                  r0_d    = mute_4000(r0_q);
                  chg_d   = 1'b1;
               end
            end
            PLAY: begin
               if (tick) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == DUR_W'(1)) begin
                     state_d = FETCH;
                     step_d  = step_q + 1'b1;
                  end
               end
            end
`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
            HOST: begin
               if (host_change) begin
                  {r3_d, r2_d, r1_d, r0_d} = host_regs;
                  chg_d = 1'b1;
               end else if (host_release) begin
                  state_d = (prev_q == PLAY) ? FETCH : prev_q;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         r0_q    <= MUTE_4000;
         r1_q    <= 8'h00;
         r2_q    <= 8'h00;
         r3_q    <= 8'h00;
         chg_q   <= 1'b0;
`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
         prev_q  <= IDLE;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         r3_q    <= r3_d;
         chg_q   <= chg_d;
`ifdef NOTE_SEQUENCER_HOST_OVERRIDE_EN
         prev_q  <= prev_d;
`endif
      end
   end

   assign reg_4000   = r0_q;
   assign reg_4001   = r1_q;
   assign reg_4002   = r2_q;
   assign reg_4003   = r3_q;
   assign reg_change = chg_q;
   assign busy       = (state_q != IDLE);
   assign step       = step_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16, number of pattern-table entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock (APU clock, ~1.79 MHz).
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port tick  input  1  one-cycle frame enable (120 Hz).
REQ-005 SHALL have ports start / stop / loop  input  1 each  start pulse / stop pulse / loop level.
REQ-006 SHALL have port tbl_we  input  1  pattern-table write strobe.
REQ-007 SHALL have ports tbl_addr  input  log2(STEPS) and tbl_data  input  23  write address and entry.
REQ-008 SHALL have ports host_regs  input  32 and host_change  input  1  UART register image {4003,4002,4001,4000} plus its change pulse.
REQ-009 SHALL have port host_release  input  1  pulse returning control to the sequencer.
REQ-010 SHALL have ports reg_4000..reg_4003  output  8 each  and reg_change  output  1  pulse driving the rectangle channel.
REQ-011 SHALL have ports busy  output  1 and step  output  log2(STEPS)  (current index).

Function
REQ-012 Entry format SHALL be [22:21] duty, [20:17] volume, [16:6] period, [5:0] duration in ticks; duration 0 = end marker.
REQ-013 The FSM SHALL have states IDLE, FETCH, PLAY, HOST.
REQ-014 IDLE + start SHALL go to FETCH with step=0.
REQ-015 FETCH SHALL take exactly one cycle (registered table read); a non-zero duration loads cnt=duration and goes to PLAY.
REQ-016 On that FETCH->PLAY transition, outputs SHALL update to reg_4000={duty,1,1,volume}, reg_4001=8'h00, reg_4002=period[7:0], reg_4003={5'b0,period[10:8]}, with reg_change high exactly one cycle, coincident with the new values.
REQ-017 In PLAY, each tick SHALL decrement cnt; a tick with cnt==1 SHALL advance step (STEPS-1 wraps to 0) and enter FETCH.
REQ-018 An end marker with loop=1 SHALL restart at step 0.
REQ-019 An end marker with loop=0, or an end marker at step 0, SHALL mute and enter IDLE.
REQ-020 Mute SHALL mean reg_4000 volume field forced to 0 with duty/flags retained, plus a one-cycle reg_change pulse.
REQ-021 stop in any state SHALL mute and enter IDLE; stop wins over a simultaneous start.
REQ-022 start while not in IDLE SHALL be ignored.
REQ-023 A table write SHALL be accepted in any state, one cycle; a write to the playing step affects only its next fetch.
REQ-024 A write and a FETCH of the same address in the same cycle SHALL return the old entry.
REQ-025 busy SHALL be 1 in FETCH, PLAY and HOST.

Reset
REQ-026 rst_n=0 on a clk edge SHALL force IDLE, step=0, cnt=0, reg_4000=8'h30, reg_4001..reg_4003=8'h00, reg_change=0, busy=0.
REQ-027 Reset SHALL NOT clear the pattern table; contents after power-up are undefined.
REQ-028 Reset asserted mid-PLAY SHALL NOT emit a reg_change pulse.

Configuration
REQ-029 Macro NOTE_SEQUENCER_HOST_OVERRIDE_EN defined: host_change in FETCH/PLAY/IDLE SHALL enter HOST, copy host_regs to the outputs and pulse reg_change.
REQ-030 With the macro defined, further host_change pulses in HOST SHALL recopy and pulse; cnt and step are frozen.
REQ-031 With the macro defined, host_release SHALL return to the prior state; from PLAY, via FETCH of the current step.
REQ-032 With the macro defined, stop in HOST SHALL go to IDLE.
REQ-033 Macro undefined: HOST state, host_* ports' effect and related logic SHALL be absent; ports remain, ignored.

Structure
REQ-034 A shared package SHALL hold the state enum, entry field offsets/widths, the 23-bit entry type and the mute/reset constant 8'h30.
REQ-035 The pattern table SHALL be a separate sub-module seq_table (synchronous-write, registered-read RAM).

Verification
REQ-036 Table {0:duty2,vol15,period 0x1FD,dur 3; 1:dur 0}, loop=0, start -> reg_4002=0xFD, reg_4003=0x01, reg_4000=0xBF, one reg_change; 3 ticks later mute (0xB0) and busy=0.
REQ-037 Same table with loop=1 -> step 0 reloads every 3 ticks; reg_change once per reload; step never exceeds 1.
REQ-038 STEPS=16, all entries dur=1, loop=1 -> step sequence 0..15,0 across 16 ticks, no gaps.
REQ-039 start and stop same cycle from IDLE -> stays IDLE, mute pulse, busy=0; stop mid-PLAY -> IDLE next cycle.
REQ-040 Macro defined: host_change=1 with host_regs=0x08_55_00_7F during PLAY -> outputs equal host image, cnt frozen across 10 ticks; host_release -> refetch of same step.
REQ-041 rst_n low for one cycle mid-PLAY -> all outputs at reset values, no reg_change, table contents intact on next start.
